// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the UART transmit-path arbiter.
//   state_t    : arbiter FSM states (IDLE, HDR, XFER)
//   HDR_MAGIC  : upper nibble of the optional per-packet header byte
//   clog2      : width helper for grant index and stall counter (min 1)
// The HDR state is only reachable when UART_ARB_HDR_EN is defined.
package uart_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    localparam logic [3:0] HDR_MAGIC = 4'hA;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) begin
                r = i + 1;
            end
        end
        if (r == 0) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client-side streams plus the UART TX FIFO write port, bundled together.
//   req_valid/req_data/req_last : per-client byte streams (client i at [i*D_bits +: D_bits])
//   req_ready                   : per-client beat acceptance
//   w_data/wr_uart              : TX FIFO din / wr_en
//   tx_full                     : TX FIFO full
// slave  : arbiter view.  master : clients + FIFO view.
interface uart_tx_arbiter_if #(
    parameter int unsigned N_REQ  = 4,
    parameter int unsigned D_bits = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*D_bits-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;
    logic [D_bits-1:0]       w_data;
    logic                    wr_uart;
    logic                    tx_full;

    modport slave (
        input  req_valid, req_data, req_last, tx_full,
        output req_ready, w_data, wr_uart
    );

    modport master (
        output req_valid, req_data, req_last, tx_full,
        input  req_ready, w_data, wr_uart
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational rotating-priority encoder.
//   req     : request vector
//   rr_ptr  : last served client; search starts at rr_ptr+1 (mod N_REQ)
//   gnt_idx : index of the first requester found
//   gnt_vld : any request present
module uart_tx_arbiter_rr_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ = 4
) (
    input  logic [N_REQ-1:0]        req,
    input  logic [clog2(N_REQ)-1:0] rr_ptr,
    output logic [clog2(N_REQ)-1:0] gnt_idx,
    output logic                    gnt_vld
);
    localparam int unsigned GW = clog2(N_REQ);

    // Offset i walks the priority order; only one client j matches each offset.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            for (int unsigned j = 0; j < N_REQ; j++) begin
                if (!gnt_vld && req[j] && (j == (32'(rr_ptr) + i + 1) % N_REQ)) begin
                    gnt_vld = 1'b1;
                    gnt_idx = GW'(j);
                end
            end
        end
    end
endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the UART TX FIFO write port among N_REQ packet-streaming clients.
// Grants rotate round-robin and are held until the last byte of a packet is
// accepted or the granted client goes TIMEOUT cycles without valid data.
//   clk, reset : clock, synchronous active-high reset
//   bus        : uart_tx_arbiter_if.slave (client streams + TX FIFO port)
//   grant_id   : current owner (meaningful while busy)
//   busy       : grant held
//   abort      : one-cycle pulse when a grant is revoked by timeout
// Optional feature: define UART_ARB_HDR_EN to prefix each packet with a
// header byte {HDR_MAGIC, grant_id}.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned D_bits  = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    uart_tx_arbiter_if.slave        bus,
    output logic [clog2(N_REQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    abort
);
    localparam int unsigned GW = clog2(N_REQ);
    localparam int unsigned SW = clog2(TIMEOUT);

    state_t        state_q,  state_d;
    logic [GW-1:0] grant_q,  grant_d;
    logic [GW-1:0] rr_ptr_q, rr_ptr_d;
    logic [SW-1:0] stall_q,  stall_d;
    logic          abort_q,  abort_d;

    logic [GW-1:0]     arb_idx;
    logic              arb_vld;
    logic              g_valid;
    logic              g_last;
    logic [D_bits-1:0] g_data;

    uart_tx_arbiter_rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req     (bus.req_valid),
        .rr_ptr  (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Select the granted client's stream.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                g_valid = bus.req_valid[i];
                g_last  = bus.req_last[i];
                g_data  = bus.req_data[i*D_bits +: D_bits];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        stall_d       = stall_q;
        abort_d       = 1'b0;
        bus.req_ready = '0;
        bus.wr_uart   = 1'b0;
        bus.w_data    = '0;

        case (state_q)
            ST_IDLE: begin
                stall_d = '0;
                if (arb_vld) begin
                    grant_d = arb_idx;
`ifdef UART_ARB_HDR_EN
                    state_d = ST_HDR;
`else
                    state_d = ST_XFER;
`endif
                end
            end
`ifdef UART_ARB_HDR_EN
            ST_HDR: begin
                bus.w_data = D_bits'({HDR_MAGIC, 4'(grant_q)});
                if (!bus.tx_full) begin
                    bus.wr_uart = 1'b1;
                    state_d     = ST_XFER;
                end
            end
`endif
            ST_XFER: begin
                bus.w_data = g_data;
                // A full FIFO freezes everything, including the stall counter.
                if (!bus.tx_full) begin
                    bus.req_ready = N_REQ'(1) << grant_q;
                    if (g_valid) begin
                        bus.wr_uart = 1'b1;
                        stall_d     = '0;
                        if (g_last) begin
                            rr_ptr_d = grant_q;
                            state_d  = ST_IDLE;
                        end
                    end else if (stall_q == SW'(TIMEOUT - 1)) begin
                        abort_d  = 1'b1;
                        rr_ptr_d = grant_q;
                        stall_d  = '0;
                        state_d  = ST_IDLE;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Block any handshake while reset is asserted, even before the state clears.
        if (reset) begin
            bus.req_ready = '0;
            bus.wr_uart   = 1'b0;
            bus.w_data    = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= GW'(N_REQ - 1);
            stall_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            stall_q  <= stall_d;
            abort_q  <= abort_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q != ST_IDLE);
    assign abort    = abort_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DB = 8;
    localparam int unsigned TO = 16;
`ifdef UART_ARB_HDR_EN
    localparam int HB = 1;
`else
    localparam int HB = 0;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] grant_id;
    logic       busy;
    logic       abort;

    uart_tx_arbiter_if #(.N_REQ(N), .D_bits(DB)) bus ();

    uart_tx_arbiter #(.N_REQ(N), .D_bits(DB), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy),
        .abort    (abort)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int n_writes = 0;
    bit auto_drv = 1'b0;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t      cq [N][$];
    logic [7:0] sb [$];

    typedef struct {
        logic [3:0] v;
        logic [7:0] d;
        logic       l;
        logic       f;
        logic       busy;
        logic [1:0] g;
        logic       wr;
        logic [7:0] wd;
        logic [3:0] rdy;
    } vec_t;

    vec_t tv [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic q(input int c, input logic [7:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        cq[c].push_back(b);
    endtask

    task automatic exp_hdr(input int c);
        if (HB != 0) sb.push_back({4'hA, 4'(c)});
    endtask

    function automatic bit all_cq_empty();
        for (int i = 0; i < N; i++) if (cq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // UART-side monitor: every write must match the scoreboard head.
    always @(negedge clk) begin
        if (bus.wr_uart === 1'b1) begin
            n_writes++;
            chk("wr_while_full", 32'(bus.tx_full), 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got %0h expected no write", bus.w_data);
            end else begin
                chk("w_data", 32'(bus.w_data), 32'(sb.pop_front()));
            end
        end
    end

    // Client model: advance each client's queue on an accepted beat.
    always begin
        logic [N-1:0] beat;
        @(negedge clk);
        beat = bus.req_valid & bus.req_ready;
        @(posedge clk);
        #1;
        if (auto_drv) begin
            for (int i = 0; i < N; i++) begin
                if (beat[i] && cq[i].size() > 0) void'(cq[i].pop_front());
                if (cq[i].size() > 0) begin
                    bus.req_valid[i]         = 1'b1;
                    bus.req_data[i*DB +: DB] = cq[i][0].data;
                    bus.req_last[i]          = cq[i][0].last;
                end else begin
                    bus.req_valid[i] = 1'b0;
                    bus.req_last[i]  = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        auto_drv = 1'b0;
        for (int i = 0; i < N; i++) cq[i].delete();
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.tx_full   = 1'b0;
        n_writes      = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic wait_writes(input int target, input string name, input int budget);
        int k;
        k = 0;
        while (n_writes < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({name, "_writes_seen"}, 32'(n_writes >= target), 32'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((sb.size() != 0 || !all_cq_empty()) && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({name, "_pending_bytes"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          v        d      l     f     busy  g     wr    wd     rdy
        tv[0] = '{4'b0100, 8'h11, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'b0000};
        tv[1] = '{4'b0100, 8'h11, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 8'h11, 4'b0100};
        tv[2] = '{4'b0100, 8'h22, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 4'b0000};
        tv[3] = '{4'b0100, 8'h22, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 4'b0000};
        tv[4] = '{4'b0101, 8'h22, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 8'h22, 4'b0100};
        tv[5] = '{4'b0101, 8'h33, 1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 8'h33, 4'b0100};
        tv[6] = '{4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 8'h00, 4'b0000};

        // Reset held with every client requesting.
        bus.req_valid = '1;
        bus.req_last  = '0;
        bus.req_data  = '0;
        bus.tx_full   = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_wr", 32'(bus.wr_uart), 32'd0);
            chk("rst_ready", 32'(bus.req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        reset         = 1'b0;
        bus.req_valid = '0;

`ifndef UART_ARB_HDR_EN
        // Single client 2 packet with backpressure, cycle by cycle.
        sb.push_back(8'h11);
        sb.push_back(8'h22);
        sb.push_back(8'h33);
        for (int r = 0; r < 7; r++) begin
            bus.req_valid = tv[r].v;
            bus.req_data  = {8'hEE, tv[r].d, 8'hEE, 8'hEE};
            bus.req_last  = {1'b0, tv[r].l, 2'b00};
            bus.tx_full   = tv[r].f;
            @(negedge clk);
            chk($sformatf("t2_r%0d_busy", r), 32'(busy), 32'(tv[r].busy));
            if (tv[r].busy) chk($sformatf("t2_r%0d_grant", r), 32'(grant_id), 32'(tv[r].g));
            chk($sformatf("t2_r%0d_wr", r), 32'(bus.wr_uart), 32'(tv[r].wr));
            if (tv[r].wr) chk($sformatf("t2_r%0d_wdata", r), 32'(bus.w_data), 32'(tv[r].wd));
            chk($sformatf("t2_r%0d_ready", r), 32'(bus.req_ready), 32'(tv[r].rdy));
            @(posedge clk);
            #1;
        end
        chk("t2_pending_bytes", 32'(sb.size()), 32'd0);
`endif

        // Simultaneous requests, then client 0 re-requests behind others.
        do_reset();
        q(0, 8'hA0, 1'b0); q(0, 8'hA1, 1'b1); q(0, 8'hE0, 1'b0); q(0, 8'hE1, 1'b1);
        q(1, 8'hB0, 1'b0); q(1, 8'hB1, 1'b1);
        q(3, 8'hD0, 1'b0); q(3, 8'hD1, 1'b1);
        exp_hdr(0); sb.push_back(8'hA0); sb.push_back(8'hA1);
        exp_hdr(1); sb.push_back(8'hB0); sb.push_back(8'hB1);
        exp_hdr(3); sb.push_back(8'hD0); sb.push_back(8'hD1);
        exp_hdr(0); sb.push_back(8'hE0); sb.push_back(8'hE1);
        auto_drv = 1'b1;
        wait_drain("t3", 200);

        // FIFO full for 20 cycles mid-packet (longer than TIMEOUT).
        do_reset();
        for (int i = 0; i < 5; i++) begin
            q(1, 8'hC0 + 8'(i), (i == 4) ? 1'b1 : 1'b0);
        end
        exp_hdr(1);
        for (int i = 0; i < 5; i++) sb.push_back(8'hC0 + 8'(i));
        auto_drv = 1'b1;
        wait_writes(HB + 2, "t4_start", 50);
        @(posedge clk);
        #1 bus.tx_full = 1'b1;
        repeat (20) begin
            @(negedge clk);
            chk("t4_full_wr", 32'(bus.wr_uart), 32'd0);
            chk("t4_full_ready", 32'(bus.req_ready), 32'd0);
            chk("t4_full_abort", 32'(abort), 32'd0);
            chk("t4_full_busy", 32'(busy), 32'd1);
        end
        @(posedge clk);
        #1 bus.tx_full = 1'b0;
        wait_drain("t4", 100);

        // Granted client stalls after one byte; client 3 waits.
        do_reset();
        q(1, 8'h77, 1'b0);
        q(3, 8'h31, 1'b0); q(3, 8'h32, 1'b1);
        exp_hdr(1); sb.push_back(8'h77);
        exp_hdr(3); sb.push_back(8'h31); sb.push_back(8'h32);
        auto_drv = 1'b1;
        wait_writes(HB + 1, "t5_first", 50);
        for (int k = 1; k <= TO; k++) begin
            @(negedge clk);
            chk($sformatf("t5_idle%0d_abort", k), 32'(abort), 32'd0);
            chk($sformatf("t5_idle%0d_busy", k), 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("t5_abort_pulse", 32'(abort), 32'd1);
        chk("t5_abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("t5_abort_end", 32'(abort), 32'd0);
        chk("t5_regrant_busy", 32'(busy), 32'd1);
        chk("t5_regrant_id", 32'(grant_id), 32'd3);
        wait_drain("t5", 100);

        // Reset mid-packet: writes stop at once, state clears next cycle.
        do_reset();
        for (int i = 0; i < 4; i++) q(2, 8'h90 + 8'(i), (i == 3) ? 1'b1 : 1'b0);
        exp_hdr(2);
        for (int i = 0; i < 4; i++) sb.push_back(8'h90 + 8'(i));
        auto_drv = 1'b1;
        wait_writes(HB + 2, "t7_start", 50);
        @(posedge clk);
        #1;
        reset    = 1'b1;
        auto_drv = 1'b0;
        @(negedge clk);
        chk("t7_rst_wr", 32'(bus.wr_uart), 32'd0);
        chk("t7_rst_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_write_count", 32'(n_writes), 32'(HB + 2));
        sb.delete();

        // Client 3 single-byte packet (header-prefixed when enabled).
        do_reset();
        q(3, 8'h55, 1'b1);
        exp_hdr(3);
        sb.push_back(8'h55);
        auto_drv = 1'b1;
        wait_drain("t6", 50);
        repeat (2) @(negedge clk);
        chk("t6_busy_after", 32'(busy), 32'd0);
        chk("t6_write_count", 32'(n_writes), 32'(HB + 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
